writeback_unit_csr: RTL and testbench
=====================================

Name: writeback_unit_csr

Overview:
Writeback stage of the base single-issue RISC-V pipeline. It selects the register-file write data from the ALU result, the load data from memory, or CSR read data. It forwards the write enable and destination register to the register file. The write path is purely combinational. A free-running cycle counter drives a simulation-only scan/debug print.

Parameters:
CORE, 0, core index; printed in scan output only.
DATA_WIDTH, 32, width of all data buses.
SCAN_CYCLES_MIN, 0, first cycle-counter value at which scan printing is allowed.
SCAN_CYCLES_MAX, 1000, last cycle-counter value at which scan printing is allowed.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset.
opWrite  input  1  instruction writes the register file.
opSel  input  1  0 = ALU result, 1 = memory load data.
CSR_read_data_valid  input  1  CSR read data present; takes priority over opSel.
opReg  input  5  destination register index.
ALU_result  input  DATA_WIDTH  ALU/execute result.
CSR_read_data  input  DATA_WIDTH  data read from the CSR file.
memory_data  input  DATA_WIDTH  load data from the data memory interface.
write  output  1  register-file write enable.
write_reg  output  5  register-file write address.
write_data  output  DATA_WIDTH  register-file write data.
scan  input  1  enables the simulation debug print.

Behaviour:
- Data paths are combinational with zero latency. Outputs follow inputs in the same cycle, with no registers in the data path.
- write = opWrite.
- write_reg = opReg, passed through unmodified. Suppression of writes to x0 is not done here; the register file handles it.
- write_data priority:
  - If CSR_read_data_valid = 1: write_data = CSR_read_data.
  - Else if opSel = 1: write_data = memory_data.
  - Else: write_data = ALU_result.
- CSR_read_data_valid overrides opSel whenever both are 1.
- No arithmetic, sign extension or width conversion. Load alignment and extension are done upstream, and all buses are DATA_WIDTH wide.
- Reset:
  - Outputs are not gated by reset; write, write_reg and write_data track their inputs during reset.
  - Only the internal cycle counter is reset.
- Cycle counter:
  - Width 32.
  - On a rising edge with reset = 0, the counter loads 0.
  - Otherwise it increments by 1 each cycle and wraps from 0xFFFFFFFF to 0.
  - Reset asserted mid-run zeros the counter on the next edge.
- Scan print (simulation only, inside translate_off or an equivalent guard):
  - On each rising edge, print when scan = 1 and SCAN_CYCLES_MIN <= counter <= SCAN_CYCLES_MAX.
  - Printed fields: core number, cycle count, opWrite, opSel, CSR_read_data_valid, opReg, ALU_result, memory_data, CSR_read_data, write, write_reg, write_data.
  - The print has no effect on outputs.
- No handshake and no stall input. Pipeline stalls and bubbles are expressed upstream by opWrite = 0.

Test Plan:
1. opWrite=1, opSel=0, CSR_read_data_valid=0, ALU_result=2, CSR_read_data=1, memory_data=0, opReg=0, reset released -> write=1, write_data=2, write_reg=0.
2. Same as 1, then CSR_read_data_valid=1 -> write=1, write_data=1 in the same cycle.
3. opSel=1, CSR_read_data_valid=0, memory_data=0xDEADBEEF, ALU_result=5 -> write_data=0xDEADBEEF. Then set CSR_read_data_valid=1 with CSR_read_data=7 -> write_data=7 (CSR overrides memory).
4. opWrite=0, opReg=17 -> write=0, write_reg=17, and write_data still follows the select logic.
5. With reset held low (asserted), change ALU_result 3 -> 9 with opSel=0 and CSR_read_data_valid=0 -> write_data changes 3 -> 9 immediately (outputs not reset-gated).
6. Assert reset for 1 cycle mid-run, then enable scan -> printed cycle count restarts at 0 and increments by 1 per cycle; no print when scan=0 or the count is outside [SCAN_CYCLES_MIN, SCAN_CYCLES_MAX].

Source files
------------

// File: rtl/writeback_unit_csr.sv
// -----------------------------------------------------------------------------
// writeback_unit_csr
//
// Writeback stage of the base single-issue RISC-V pipeline. It picks the
// register-file write data from one of three sources and passes the write
// enable and the destination index straight through to the register file.
// The write path is purely combinational, with zero latency.
//
// A free-running 32-bit cycle counter is the only state in the block. It
// exists to timestamp a simulation-only scan/debug print.
//
// Ports
//   clock                input  system clock; state updates on the rising edge
//   reset                input  synchronous, active-low; clears the counter only
//   opWrite              input  instruction writes the register file
//   opSel                input  0 = ALU result, 1 = memory load data
//   CSR_read_data_valid  input  CSR read data present; overrides opSel
//   opReg                input  destination register index (5 bits)
//   ALU_result           input  execute-stage result
//   CSR_read_data        input  data read from the CSR file
//   memory_data          input  load data, already aligned and extended upstream
//   write                output register-file write enable (= opWrite)
//   write_reg            output register-file write address (= opReg)
//   write_data           output register-file write data
//   scan                 input  enables the simulation debug print
//
// Handshake: none. There is no valid/ready pair and no stall input. Bubbles
// and stalls arrive from upstream as opWrite = 0, and this stage forwards
// whatever it is given in the same cycle.
// -----------------------------------------------------------------------------
module writeback_unit_csr #(
  parameter int          CORE            = 0,
  parameter int          DATA_WIDTH      = 32,
  parameter logic [31:0] SCAN_CYCLES_MIN = 32'd0,
  parameter logic [31:0] SCAN_CYCLES_MAX = 32'd1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  opWrite,
  input  logic                  opSel,
  input  logic                  CSR_read_data_valid,
  input  logic [4:0]            opReg,
  input  logic [DATA_WIDTH-1:0] ALU_result,
  input  logic [DATA_WIDTH-1:0] CSR_read_data,
  input  logic [DATA_WIDTH-1:0] memory_data,
  output logic                  write,
  output logic [4:0]            write_reg,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic                  scan
);

  // ---------------------------------------------------------------------------
  // Write path. Not gated by reset: the outputs track their inputs even while
  // reset is asserted. Writes to x0 are not suppressed here; the register file
  // discards them.
  // ---------------------------------------------------------------------------
  assign write     = opWrite;
  assign write_reg = opReg;

  // CSR data wins over the opSel choice whenever it is valid.
  always_comb begin
    write_data = ALU_result;
    if (CSR_read_data_valid) begin
      write_data = CSR_read_data;
    end else if (opSel) begin
      write_data = memory_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Cycle counter. Wraps naturally from 0xFFFFFFFF to 0.
  // ---------------------------------------------------------------------------
  logic [31:0] cycles_q;
  logic [31:0] cycles_d;

  assign cycles_d = cycles_q + 32'd1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cycles_q <= 32'd0;
    end else begin
      cycles_q <= cycles_d;
    end
  end

`ifndef SYNTHESIS
  // ---------------------------------------------------------------------------
  // Scan/debug print. Observes only; it drives nothing.
  // The window test is done as a signed 33-bit compare so that a zero lower
  // bound does not turn into a constant-true unsigned comparison.
  // ---------------------------------------------------------------------------
  logic in_window;

  assign in_window =
      ($signed({1'b0, cycles_q}) >= $signed({1'b0, SCAN_CYCLES_MIN})) &&
      ($signed({1'b0, cycles_q}) <= $signed({1'b0, SCAN_CYCLES_MAX}));

  always @(posedge clock) begin
    if (scan && in_window) begin
      $display("[scan] core=%0d cycle=%0d opWrite=%0b opSel=%0b csr_valid=%0b opReg=%0d alu=%h mem=%h csr=%h | write=%0b write_reg=%0d write_data=%h",
               CORE, cycles_q, opWrite, opSel, CSR_read_data_valid, opReg,
               ALU_result, memory_data, CSR_read_data,
               write, write_reg, write_data);
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit_csr.sv
// -----------------------------------------------------------------------------
// Bench for writeback_unit_csr. Directed steps followed by random traffic, all
// checked against a behavioural reference model held in the bench.
// -----------------------------------------------------------------------------
module tb_writeback_unit_csr;

  localparam int DW = 32;

  // clock / reset
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          opWrite;
  logic          opSel;
  logic          CSR_read_data_valid;
  logic [4:0]    opReg;
  logic [DW-1:0] ALU_result;
  logic [DW-1:0] CSR_read_data;
  logic [DW-1:0] memory_data;
  logic          write;
  logic [4:0]    write_reg;
  logic [DW-1:0] write_data;
  logic          scan;

  writeback_unit_csr #(
    .CORE            (3),
    .DATA_WIDTH      (DW),
    .SCAN_CYCLES_MIN (32'd2),
    .SCAN_CYCLES_MAX (32'd6)
  ) dut (
    .clock               (clock),
    .reset               (reset),
    .opWrite             (opWrite),
    .opSel               (opSel),
    .CSR_read_data_valid (CSR_read_data_valid),
    .opReg               (opReg),
    .ALU_result          (ALU_result),
    .CSR_read_data       (CSR_read_data),
    .memory_data         (memory_data),
    .write               (write),
    .write_reg           (write_reg),
    .write_data          (write_data),
    .scan                (scan)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state: the expected counter value
  logic [31:0] exp_cnt = 32'd0;

  // reference model for the write data: pick the active source by priority
  function automatic logic [DW-1:0] ref_data(input logic csr_v, input logic sel,
                                             input logic [DW-1:0] alu,
                                             input logic [DW-1:0] mem,
                                             input logic [DW-1:0] csr);
    if (csr_v) return csr;
    if (sel)   return mem;
    return alu;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // compare all three outputs against the model for the current inputs
  task automatic check_outputs(input string tag);
    #1;
    check({tag, ".write"},      {31'd0, write},    {31'd0, opWrite});
    check({tag, ".write_reg"},  {27'd0, write_reg}, {27'd0, opReg});
    check({tag, ".write_data"}, write_data,
          ref_data(CSR_read_data_valid, opSel, ALU_result, memory_data, CSR_read_data));
  endtask

  // one clock edge; the model counter follows the reset value seen at the edge
  task automatic tick(input string tag);
    @(posedge clock);
    if (!reset) exp_cnt = 32'd0;
    else        exp_cnt = exp_cnt + 32'd1;
    #1;
    check({tag, ".cycles"}, dut.cycles_q, exp_cnt);
  endtask

  task automatic drive(input logic w, input logic sel, input logic csr_v,
                       input logic [4:0] rd, input logic [DW-1:0] alu,
                       input logic [DW-1:0] csr, input logic [DW-1:0] mem);
    opWrite = w; opSel = sel; CSR_read_data_valid = csr_v; opReg = rd;
    ALU_result = alu; CSR_read_data = csr; memory_data = mem;
  endtask

  initial begin
    reset = 1'b0;
    scan  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd3, 32'd0, 32'd0);

    // reset held: counter clears, outputs still follow inputs
    tick("rst0");
    tick("rst1");
    check_outputs("rst_alu3");
    ALU_result = 32'd9;
    check_outputs("rst_alu9");
    check("rst_alu9_literal", write_data, 32'd9);

    // 1. ALU path after reset release
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'd2, 32'd1, 32'd0);
    check_outputs("t1");
    check("t1_literal", write_data, 32'd2);
    tick("t1");

    // 2. CSR valid takes over in the same cycle
    CSR_read_data_valid = 1'b1;
    check_outputs("t2");
    check("t2_literal", write_data, 32'd1);
    tick("t2");

    // 3. memory path, then CSR overrides memory
    drive(1'b1, 1'b1, 1'b0, 5'd4, 32'd5, 32'd0, 32'hDEADBEEF);
    check_outputs("t3_mem");
    check("t3_mem_literal", write_data, 32'hDEADBEEF);
    CSR_read_data_valid = 1'b1;
    CSR_read_data = 32'd7;
    check_outputs("t3_csr");
    check("t3_csr_literal", write_data, 32'd7);
    tick("t3");

    // 4. bubble: write low, index still passed, data still selected
    drive(1'b0, 1'b1, 1'b0, 5'd17, 32'h1111, 32'h2222, 32'h3333);
    check_outputs("t4");
    check("t4_write_reg_literal", {27'd0, write_reg}, 32'd17);
    tick("t4");

    // random traffic
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom, $urandom, $urandom);
      check_outputs("rand");
      tick("rand");
    end

    // 6. one-cycle reset mid-run, then scan on; counter restarts at 0
    reset = 1'b0;
    tick("mid_rst");
    check("mid_rst_zero", dut.cycles_q, 32'd0);
    reset = 1'b1;
    scan  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
      check_outputs("scan");
      tick("scan");
    end
    check("scan_count_literal", dut.cycles_q, 32'd10);
    scan = 1'b0;
    tick("scan_off");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout reached before end of sequence");
    $fatal(1, "timeout");
  end

endmodule
